fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage upstream of instr_mem. Owns the program counter, drives
//  pc into instr_mem, and captures the returned instruction into the IF/ID pipeline
//  register. Handles sequential advance, stall hold, and branch/jump redirect with flush.
// PARAMETERS
//  ADDR_WIDTH   32    width of pc and all address ports
//  INSTR_WIDTH  32    width of instruction word
//  RESET_PC     0     pc value loaded on reset
//  PC_STEP      4     increment applied on sequential fetch
//  NOP_INSTR    32'h00000013  bubble inserted into IF/ID on reset/flush (addi x0,x0,0)
// PORTS
//  clk          in   1            clock, rising edge
//  rst          in   1            asynchronous, active-high reset
//  stall        in   1            hold pc and IF/ID (hazard unit)
//  pc_src       in   1            redirect request (taken branch / jump)
//  pc_target    in   ADDR_WIDTH   redirect destination
//  pc           out  ADDR_WIDTH   fetch address to instr_mem
//  instr        in   INSTR_WIDTH  instruction returned combinationally by instr_mem
//  id_instr     out  INSTR_WIDTH  IF/ID instruction
//  id_pc        out  ADDR_WIDTH   IF/ID pc of id_instr
//  id_pc_plus4  out  ADDR_WIDTH   IF/ID id_pc + PC_STEP
//  id_valid     out  1            IF/ID holds a real instruction (0 = bubble)
//  fetch_count  out  32           number of valid instructions loaded into IF/ID
//  misalign_err out  1            sticky misaligned-redirect flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, immediate, any cycle incl. mid-redirect): pc=RESET_PC, id_instr=NOP_INSTR,
//    id_pc=0, id_pc_plus4=0, id_valid=0, fetch_count=0, misalign_err=0.
//  - instr_mem read is combinational: instr corresponds to current pc in same cycle.
//  - Per rising edge, priority pc_src > stall > advance:
//    * pc_src=1: pc<=pc_target; IF/ID flushed (id_instr<=NOP_INSTR, id_valid<=0,
//      id_pc/id_pc_plus4 hold); fetch_count holds. Applies even when stall=1.
//    * stall=1, pc_src=0: pc and all IF/ID outputs hold; fetch_count holds.
//    * else: pc<=pc+PC_STEP; id_instr<=instr; id_pc<=pc; id_pc_plus4<=pc+PC_STEP;
//      id_valid<=1; fetch_count<=fetch_count+1.
//  - Latency: instruction at pc appears on id_* one cycle after pc is presented
//    (first id_valid=1 on 1st edge after rst deasserts, id_pc=RESET_PC).
//  - Redirect penalty: exactly one bubble; target instr valid in IF/ID 2 edges after pc_src.
//  - Arithmetic: pc+PC_STEP modulo 2^ADDR_WIDTH (wraps to 0, no flag).
//  - fetch_count wraps modulo 2^32.
//  - pc_target sampled only when pc_src=1; otherwise ignored.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: on redirect with pc_target[1:0]!=0, pc<=pc_target with
//    bits[1:0] cleared and misalign_err<=1 (sticky until rst). Aligned targets unchanged.
//  Not defined: pc_target loaded verbatim; misalign_err tied 0.
// TESTING
//  1 rst high then low, stall=0,pc_src=0 -> pc 0,4,8; after 1st edge id_pc=0,id_valid=1,
//    id_pc_plus4=4; after 3 edges fetch_count=3.
//  2 stall=1 for 2 cycles at pc=8 -> pc stays 8, id_* unchanged, fetch_count unchanged;
//    release -> pc=12, id_pc=8.
//  3 pc_src=1,pc_target=0x40 at pc=0x10 -> next pc=0x40,id_valid=0,id_instr=0x00000013;
//    next edge id_pc=0x40,id_valid=1.
//  4 pc_src=1 and stall=1 same cycle, target=0x80 -> pc=0x80, bubble inserted.
//  5 RESET_PC=32'hFFFFFFFC -> after 1 edge pc=0, id_pc=0xFFFFFFFC, id_pc_plus4=0.
//  6 FETCH_ALIGN_CHECK_EN: redirect to 0x42 -> pc=0x40, misalign_err=1 and stays 1;
//    rst asserted mid-run -> all outputs immediately to reset values.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the pc, feeds instr_mem and loads the IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN: word-align redirect targets and flag misalignment.
module fetch_stage #(
   parameter int unsigned               ADDR_WIDTH  = 32,
   parameter int unsigned               INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]     RESET_PC    = '0,
   parameter int unsigned               PC_STEP     = 4,
   parameter logic [INSTR_WIDTH-1:0]    NOP_INSTR   = 32'h0000_0013
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   stall_i,
   input  logic                   pc_src_i,
   input  logic [ADDR_WIDTH-1:0]  pc_target_i,
   output logic [ADDR_WIDTH-1:0]  pc_o,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   output logic [INSTR_WIDTH-1:0] id_instr_o,
   output logic [ADDR_WIDTH-1:0]  id_pc_o,
   output logic [ADDR_WIDTH-1:0]  id_pc_plus4_o,
   output logic                   id_valid_o,
   output logic [31:0]            fetch_count_o,
   output logic                   misalign_err_o
);

   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [ADDR_WIDTH-1:0]  pc;
      logic [ADDR_WIDTH-1:0]  pc_plus4;
      logic                   valid;
   } if_id_t;

   typedef enum logic [1:0] {
      ACT_ADVANCE  = 2'd0,
      ACT_HOLD     = 2'd1,
      ACT_REDIRECT = 2'd2
   } act_e;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] target;
   if_id_t                ifid_q, ifid_d;
   logic [31:0]           cnt_q, cnt_d;
   act_e                  act;

   // Redirect outranks stall so a taken branch is never lost behind a hazard.
   always_comb begin
      act = ACT_ADVANCE;
      if (pc_src_i)
         act = ACT_REDIRECT;
      else if (stall_i)
         act = ACT_HOLD;
   end

   assign pc_inc = pc_q + STEP;

`ifdef FETCH_ALIGN_CHECK_EN
   logic mis_q, mis_d;
   logic target_mis;

   assign target_mis = |pc_target_i[1:0];
   assign target     = {pc_target_i[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      mis_d = mis_q;
      if (act == ACT_REDIRECT && target_mis)
         mis_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         mis_q <= 1'b0;
      else
         mis_q <= mis_d;
   end

   assign misalign_err_o = mis_q;
`else
   assign target         = pc_target_i;
   assign misalign_err_o = 1'b0;
`endif

   always_comb begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      cnt_d  = cnt_q;
      unique case (act)
         ACT_REDIRECT: begin
            pc_d         = target;
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
         end
         ACT_HOLD: begin
         end
         default: begin
            pc_d            = pc_inc;
            ifid_d.instr    = instr_i;
            ifid_d.pc       = pc_q;
            ifid_d.pc_plus4 = pc_inc;
            ifid_d.valid    = 1'b1;
            cnt_d           = cnt_q + 32'd1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q            <= RESET_PC;
         ifid_q.instr    <= NOP_INSTR;
         ifid_q.pc       <= '0;
         ifid_q.pc_plus4 <= '0;
         ifid_q.valid    <= 1'b0;
         cnt_q           <= '0;
      end else begin
         pc_q   <= pc_d;
         ifid_q <= ifid_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pc_o          = pc_q;
   assign id_instr_o    = ifid_q.instr;
   assign id_pc_o       = ifid_q.pc;
   assign id_pc_plus4_o = ifid_q.pc_plus4;
   assign id_valid_o    = ifid_q.valid;
   assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a second instance checks pc wrap from RESET_PC.
// Build with +define+FETCH_ALIGN_CHECK_EN to cover the alignment checker.
module tb_fetch_stage;

   localparam logic [31:0] K   = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        pc_src;
   logic [31:0] pc_target;
   logic [31:0] pc, instr, id_instr, id_pc, id_pc_plus4, fcnt;
   logic        id_valid, mis;
   logic [31:0] pc2, instr2, id_instr2, id_pc2, id_pc_plus42, fcnt2;
   logic        id_valid2, mis2;

   int checks = 0;
   int errors = 0;

   assign instr  = pc ^ K;
   assign instr2 = pc2 ^ K;

   fetch_stage dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .pc_src_i(pc_src),
      .pc_target_i(pc_target), .pc_o(pc), .instr_i(instr),
      .id_instr_o(id_instr), .id_pc_o(id_pc), .id_pc_plus4_o(id_pc_plus4),
      .id_valid_o(id_valid), .fetch_count_o(fcnt), .misalign_err_o(mis)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .pc_src_i(pc_src),
      .pc_target_i(pc_target), .pc_o(pc2), .instr_i(instr2),
      .id_instr_o(id_instr2), .id_pc_o(id_pc2), .id_pc_plus4_o(id_pc_plus42),
      .id_valid_o(id_valid2), .fetch_count_o(fcnt2), .misalign_err_o(mis2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_id(input string tag, input logic [31:0] e_pc,
                         input logic [31:0] e_ipc, input logic [31:0] e_ins,
                         input logic e_v, input logic [31:0] e_cnt);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".id_pc"}, id_pc, e_ipc);
      chk({tag, ".id_pc4"}, id_pc_plus4, e_ipc + 32'd4);
      chk({tag, ".id_instr"}, id_instr, e_ins);
      chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_v});
      chk({tag, ".cnt"}, fcnt, e_cnt);
   endtask

   initial begin
      rst       = 1'b1;
      stall     = 1'b0;
      pc_src    = 1'b0;
      pc_target = 32'hDEAD_0000;
      tick();
      tick();
      chk("rst.pc", pc, 32'h0);
      chk("rst.id_instr", id_instr, NOP);
      chk("rst.id_pc", id_pc, 32'h0);
      chk("rst.id_pc4", id_pc_plus4, 32'h0);
      chk("rst.id_valid", {31'd0, id_valid}, 32'd0);
      chk("rst.cnt", fcnt, 32'd0);
      chk("rst.mis", {31'd0, mis}, 32'd0);
      chk("rst.pc2", pc2, 32'hFFFF_FFFC);
      rst = 1'b0;

      tick();
      chk_id("seq1", 32'h4, 32'h0, 32'h0 ^ K, 1'b1, 32'd1);
      chk("wrap.pc", pc2, 32'h0);
      chk("wrap.id_pc", id_pc2, 32'hFFFF_FFFC);
      chk("wrap.id_pc4", id_pc_plus42, 32'h0);
      chk("wrap.id_instr", id_instr2, 32'hFFFF_FFFC ^ K);
      tick();
      chk_id("seq2", 32'h8, 32'h4, 32'h4 ^ K, 1'b1, 32'd2);

      stall = 1'b1;
      tick();
      chk_id("stall1", 32'h8, 32'h4, 32'h4 ^ K, 1'b1, 32'd2);
      tick();
      chk_id("stall2", 32'h8, 32'h4, 32'h4 ^ K, 1'b1, 32'd2);
      stall = 1'b0;
      tick();
      chk_id("release", 32'hC, 32'h8, 32'h8 ^ K, 1'b1, 32'd3);
      tick();
      chk_id("seq4", 32'h10, 32'hC, 32'hC ^ K, 1'b1, 32'd4);

      pc_src    = 1'b1;
      pc_target = 32'h40;
      tick();
      pc_src    = 1'b0;
      pc_target = 32'hDEAD_0000;
      chk_id("redir", 32'h40, 32'hC, NOP, 1'b0, 32'd4);
      tick();
      chk_id("redir+1", 32'h44, 32'h40, 32'h40 ^ K, 1'b1, 32'd5);

      pc_src    = 1'b1;
      stall     = 1'b1;
      pc_target = 32'h80;
      tick();
      pc_src    = 1'b0;
      pc_target = 32'hDEAD_0000;
      chk_id("redir_stall", 32'h80, 32'h40, NOP, 1'b0, 32'd5);
      tick();
      chk_id("bubble_hold", 32'h80, 32'h40, NOP, 1'b0, 32'd5);
      stall = 1'b0;
      tick();
      chk_id("tgt_valid", 32'h84, 32'h80, 32'h80 ^ K, 1'b1, 32'd6);

      pc_src    = 1'b1;
      pc_target = 32'h42;
      tick();
      pc_src    = 1'b0;
      pc_target = 32'hDEAD_0000;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis.pc", pc, 32'h40);
      chk("mis.flag", {31'd0, mis}, 32'd1);
      tick();
      chk("mis.pc2", pc, 32'h44);
      chk("mis.sticky", {31'd0, mis}, 32'd1);
`else
      chk("mis.pc", pc, 32'h42);
      chk("mis.flag", {31'd0, mis}, 32'd0);
      tick();
      chk("mis.pc2", pc, 32'h46);
      chk("mis.sticky", {31'd0, mis}, 32'd0);
`endif

      pc_src    = 1'b1;
      pc_target = 32'h200;
      #2;
      rst = 1'b1;
      #1;
      chk("arst.pc", pc, 32'h0);
      chk("arst.id_instr", id_instr, NOP);
      chk("arst.id_pc", id_pc, 32'h0);
      chk("arst.id_pc4", id_pc_plus4, 32'h0);
      chk("arst.id_valid", {31'd0, id_valid}, 32'd0);
      chk("arst.cnt", fcnt, 32'd0);
      chk("arst.mis", {31'd0, mis}, 32'd0);
      tick();
      chk("arst.pc_held", pc, 32'h0);
      pc_src = 1'b0;
      rst    = 1'b0;
      tick();
      chk_id("post_rst", 32'h4, 32'h0, 32'h0 ^ K, 1'b1, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
